// File: rtl/stage_id_pipe.sv
// stage_id_pipe: instruction decode stage with register file and ID/EX register.
// Decodes one instruction per cycle, reads two source registers and detects
// load-use hazards against the instruction in EX. A taken branch or jump in a
// later stage squashes decode with flush.
// Optional feature: define STAGE_ID_BYPASS_EN to forward same-cycle writeback
// data to the decode reads. Without it the reads return the old contents.
module stage_id_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           inst,
  input  logic                  in_valid,
  input  logic                  flush,
  input  logic                  WRegEn_in,
  input  logic [REG_ADDR-1:0]   wReg1,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall_out,
  output logic                  ex_valid,
  output logic                  WRegEn_out,
  output logic                  WMemEn,
  output logic                  isMemInst,
  output logic                  isBranch,
  output logic                  isJump,
  output logic [3:0]            aluctrl,
  output logic [REG_ADDR-1:0]   wReg1_out,
  output logic [DATA_WIDTH-1:0] r1_data_out,
  output logic [DATA_WIDTH-1:0] r2_data_out,
  output logic [DATA_WIDTH-1:0] imm_out
);

  localparam int NUM_REGS = 1 << REG_ADDR;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_ADDI = 4'd7,
    OP_LW   = 4'd8,
    OP_SW   = 4'd9,
    OP_BEQ  = 4'd10,
    OP_J    = 4'd11
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5
  } aluctrl_e;

  // Instruction fields
  logic [3:0]            opcode;
  logic [REG_ADDR-1:0]   rd;
  logic [REG_ADDR-1:0]   rs1;
  logic [REG_ADDR-1:0]   rs2;
  logic [DATA_WIDTH-1:0] imm_sext;

  assign opcode   = inst[31:28];
  assign rd       = inst[27 -: REG_ADDR];
  assign rs1      = inst[23 -: REG_ADDR];
  assign rs2      = inst[19 -: REG_ADDR];
  assign imm_sext = {{(DATA_WIDTH-16){inst[15]}}, inst[15:0]};

  // Not every instruction bit is a field for every REG_ADDR setting.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst;

  // Register file storage
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Writeback port: one synchronous write, register 0 is never written.
  // NOTE: the register file is cleared by reset because software may read any
  // register right after reset and must see 0; this costs a reset net on every
  // storage flop, which is acceptable for a file this small.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (WRegEn_in && (wReg1 != '0)) begin
      regs[wReg1] <= wdata;
    end
  end

  // Combinational source reads, register 0 hardwired to zero
  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] rdata2;

  // Read both sources, optionally forwarding the write in flight this cycle.
  // NOTE: every variable assigned in always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata1 = (rs1 == '0) ? '0 : regs[rs1];
    rdata2 = (rs2 == '0) ? '0 : regs[rs2];
`ifdef STAGE_ID_BYPASS_EN
    if (WRegEn_in && (wReg1 == rs1) && (rs1 != '0)) rdata1 = wdata;
    if (WRegEn_in && (wReg1 == rs2) && (rs2 != '0)) rdata2 = wdata;
`endif
  end

  // Decoded control for the instruction currently in decode
  logic       dec_wreg_en;
  logic       dec_wmem_en;
  logic       dec_is_mem;
  logic       dec_is_branch;
  logic       dec_is_jump;
  logic       dec_reads_rs1;
  logic       dec_reads_rs2;
  logic       dec_uses_imm;
  aluctrl_e   dec_alu;

  // Opcode decode table; reserved opcodes 12-15 fall through as NOP.
  always_comb begin
    dec_wreg_en   = 1'b0;
    dec_wmem_en   = 1'b0;
    dec_is_mem    = 1'b0;
    dec_is_branch = 1'b0;
    dec_is_jump   = 1'b0;
    dec_reads_rs1 = 1'b0;
    dec_reads_rs2 = 1'b0;
    dec_uses_imm  = 1'b0;
    dec_alu       = ALU_ADD;
    case (opcode)
      OP_ADD:  begin dec_wreg_en = 1'b1; dec_reads_rs1 = 1'b1; dec_reads_rs2 = 1'b1; dec_alu = ALU_ADD; end
      OP_SUB:  begin dec_wreg_en = 1'b1; dec_reads_rs1 = 1'b1; dec_reads_rs2 = 1'b1; dec_alu = ALU_SUB; end
      OP_AND:  begin dec_wreg_en = 1'b1; dec_reads_rs1 = 1'b1; dec_reads_rs2 = 1'b1; dec_alu = ALU_AND; end
      OP_OR:   begin dec_wreg_en = 1'b1; dec_reads_rs1 = 1'b1; dec_reads_rs2 = 1'b1; dec_alu = ALU_OR;  end
      OP_XOR:  begin dec_wreg_en = 1'b1; dec_reads_rs1 = 1'b1; dec_reads_rs2 = 1'b1; dec_alu = ALU_XOR; end
      OP_SLT:  begin dec_wreg_en = 1'b1; dec_reads_rs1 = 1'b1; dec_reads_rs2 = 1'b1; dec_alu = ALU_SLT; end
      OP_ADDI: begin dec_wreg_en = 1'b1; dec_reads_rs1 = 1'b1; dec_uses_imm = 1'b1; end
      OP_LW:   begin dec_wreg_en = 1'b1; dec_reads_rs1 = 1'b1; dec_uses_imm = 1'b1; dec_is_mem = 1'b1; end
      OP_SW:   begin
        dec_wmem_en = 1'b1; dec_is_mem = 1'b1; dec_uses_imm = 1'b1;
        dec_reads_rs1 = 1'b1; dec_reads_rs2 = 1'b1;
      end
      OP_BEQ:  begin
        dec_is_branch = 1'b1; dec_uses_imm = 1'b1; dec_alu = ALU_SUB;
        dec_reads_rs1 = 1'b1; dec_reads_rs2 = 1'b1;
      end
      OP_J:    dec_is_jump = 1'b1;
      default: ;
    endcase
  end

  // Load-use hazard: a LW in EX writes a register this instruction reads.
  // A load is the only memory instruction that does not write memory.
  logic ex_is_load;
  logic hazard;
  assign ex_is_load = ex_valid && isMemInst && !WMemEn;
  assign hazard     = ex_is_load && (wReg1_out != '0) &&
                      ((dec_reads_rs1 && (rs1 == wReg1_out)) ||
                       (dec_reads_rs2 && (rs2 == wReg1_out)));

  // Flush wins over stall so a squashed instruction never holds fetch.
  assign stall_out = in_valid && !flush && hazard;

  logic accept;
  assign accept = in_valid && !flush && !stall_out;

  // ID/EX register: load the decoded instruction or a zeroed bubble.
  // Source data is only presented for the registers an instruction reads.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || 1'b0) begin
      ex_valid    <= 1'b0;
      WRegEn_out  <= 1'b0;
      WMemEn      <= 1'b0;
      isMemInst   <= 1'b0;
      isBranch    <= 1'b0;
      isJump      <= 1'b0;
      aluctrl     <= 4'd0;
      wReg1_out   <= '0;
      r1_data_out <= '0;
      r2_data_out <= '0;
      imm_out     <= '0;
    end else if (!accept) begin
      ex_valid    <= 1'b0;
      WRegEn_out  <= 1'b0;
      WMemEn      <= 1'b0;
      isMemInst   <= 1'b0;
      isBranch    <= 1'b0;
      isJump      <= 1'b0;
      aluctrl     <= 4'd0;
      wReg1_out   <= '0;
      r1_data_out <= '0;
      r2_data_out <= '0;
      imm_out     <= '0;
    end else begin
      ex_valid    <= 1'b1;
      WRegEn_out  <= dec_wreg_en;
      WMemEn      <= dec_wmem_en;
      isMemInst   <= dec_is_mem;
      isBranch    <= dec_is_branch;
      isJump      <= dec_is_jump;
      aluctrl     <= dec_alu;
      wReg1_out   <= rd;
      r1_data_out <= dec_reads_rs1 ? rdata1 : '0;
      r2_data_out <= dec_reads_rs2 ? rdata2 : '0;
      imm_out     <= dec_uses_imm ? imm_sext : '0;
    end
  end

endmodule

// File: tb/tb_stage_id_pipe.sv
// tb_stage_id_pipe: scoreboard bench for stage_id_pipe with default parameters.
// The driver computes expected ID/EX contents from an instruction-level model
// and queues them; an independent monitor compares after every clock edge.
module tb_stage_id_pipe;

  localparam int DW = 32;
  localparam int RA = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   inst;
  logic          in_valid;
  logic          flush;
  logic          WRegEn_in;
  logic [RA-1:0] wReg1;
  logic [DW-1:0] wdata;
  logic          stall_out;
  logic          ex_valid, WRegEn_out, WMemEn, isMemInst, isBranch, isJump;
  logic [3:0]    aluctrl;
  logic [RA-1:0] wReg1_out;
  logic [DW-1:0] r1_data_out, r2_data_out, imm_out;

  stage_id_pipe #(.DATA_WIDTH(DW), .REG_ADDR(RA)) dut (
    .clk(clk), .rst(rst), .inst(inst), .in_valid(in_valid), .flush(flush),
    .WRegEn_in(WRegEn_in), .wReg1(wReg1), .wdata(wdata), .stall_out(stall_out),
    .ex_valid(ex_valid), .WRegEn_out(WRegEn_out), .WMemEn(WMemEn),
    .isMemInst(isMemInst), .isBranch(isBranch), .isJump(isJump),
    .aluctrl(aluctrl), .wReg1_out(wReg1_out), .r1_data_out(r1_data_out),
    .r2_data_out(r2_data_out), .imm_out(imm_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic          wen;
    logic          wmem;
    logic          mem;
    logic          br;
    logic          jmp;
    logic [3:0]    alu;
    logic [RA-1:0] wreg;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [DW-1:0] imm;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] m_regs [8];
  exp_t          m_ex;
  logic          m_ex_is_lw;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1,
                                     input int rs2, input logic [15:0] imm);
    logic [31:0] i;
    i = 32'd0;
    i[31:28] = op[3:0];
    i[27 -: RA] = rd[RA-1:0];
    i[23 -: RA] = rs1[RA-1:0];
    i[19 -: RA] = rs2[RA-1:0];
    i[15:0] = imm;
    return i;
  endfunction

  // Register read as the architecture defines it, including same-cycle writes.
  function automatic logic [DW-1:0] reg_read(input logic [RA-1:0] idx, input logic we,
                                             input logic [RA-1:0] wr, input logic [DW-1:0] wd);
    if (idx == 0) return '0;
`ifdef STAGE_ID_BYPASS_EN
    if (we && wr == idx) return wd;
`endif
    return m_regs[idx];
  endfunction

  function automatic bit reads_a(input int op); return op >= 1 && op <= 10; endfunction
  function automatic bit reads_b(input int op);
    return (op >= 1 && op <= 6) || op == 9 || op == 10;
  endfunction

  // One drive cycle: present inputs, check stall, queue the expected ID/EX state.
  task automatic step(input logic [31:0] i, input logic v, input logic f, input logic we,
                      input logic [RA-1:0] wr, input logic [DW-1:0] wd, output logic stalled);
    int op, rd, a, b;
    logic exp_stall;
    exp_t e;
    @(negedge clk);
    inst = i; in_valid = v; flush = f; WRegEn_in = we; wReg1 = wr; wdata = wd;
    #1;
    op = int'(i[31:28]); rd = int'(i[27 -: RA]); a = int'(i[23 -: RA]); b = int'(i[19 -: RA]);
    exp_stall = v && !f && m_ex_is_lw && m_ex.wreg != 0 &&
                ((reads_a(op) && a == int'(m_ex.wreg)) || (reads_b(op) && b == int'(m_ex.wreg)));
    check("stall_out", 64'(stall_out), 64'(exp_stall));
    stalled = exp_stall;
    e = '0;
    if (v && !f && !exp_stall) begin
      e.valid = 1'b1;
      e.wen   = op >= 1 && op <= 8;
      e.wmem  = op == 9;
      e.mem   = op == 8 || op == 9;
      e.br    = op == 10;
      e.jmp   = op == 11;
      case (op)
        2, 10: e.alu = 4'd1;
        3: e.alu = 4'd2;
        4: e.alu = 4'd3;
        5: e.alu = 4'd4;
        6: e.alu = 4'd5;
        default: e.alu = 4'd0;
      endcase
      e.wreg = rd[RA-1:0];
      e.r1   = reads_a(op) ? reg_read(a[RA-1:0], we, wr, wd) : '0;
      e.r2   = reads_b(op) ? reg_read(b[RA-1:0], we, wr, wd) : '0;
      e.imm  = (op == 7 || op == 8 || op == 9 || op == 10) ? DW'(signed'(i[15:0])) : '0;
    end
    sb_q.push_back(e);
    m_ex = e;
    m_ex_is_lw = e.valid && op == 8;
    if (we && wr != 0) m_regs[wr] = wd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, 64'({ex_valid, WRegEn_out, WMemEn, isMemInst, isBranch, isJump,
                               aluctrl, wReg1_out}), 64'd0);
    check({tag, "_data"}, 64'(r1_data_out | r2_data_out | imm_out), 64'd0);
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_ex = '0;
    m_ex_is_lw = 1'b0;
    for (int k = 0; k < 8; k++) m_regs[k] = '0;
  endtask

  // Monitor: the DUT presents a new ID/EX state after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("ex_valid",    64'(ex_valid),   64'(e.valid));
        check("WRegEn_out",  64'(WRegEn_out), 64'(e.wen));
        check("WMemEn",      64'(WMemEn),     64'(e.wmem));
        check("isMemInst",   64'(isMemInst),  64'(e.mem));
        check("isBranch",    64'(isBranch),   64'(e.br));
        check("isJump",      64'(isJump),     64'(e.jmp));
        check("aluctrl",     64'(aluctrl),    64'(e.alu));
        check("wReg1_out",   64'(wReg1_out),  64'(e.wreg));
        check("r1_data_out", 64'(r1_data_out), 64'(e.r1));
        check("r2_data_out", 64'(r2_data_out), 64'(e.r2));
        check("imm_out",     64'(imm_out),    64'(e.imm));
      end
    end
  end

  initial begin
    logic s;
    logic [31:0] cur;
    logic [31:0] add_dep;
    rst = 1'b1; inst = '0; in_valid = 0; flush = 0; WRegEn_in = 0; wReg1 = '0; wdata = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Write r3, then ADD rd=1 rs1=3 rs2=0.
    step(mk(0, 0, 0, 0, 0), 0, 0, 1, 3'd3, 32'h55, s);
    step(mk(1, 1, 3, 0, 0), 1, 0, 0, 0, 0, s);

    // Load-use: LW rd=2, dependent ADD stalls once, then issues.
    add_dep = mk(1, 3, 2, 1, 0);
    step(mk(8, 2, 0, 0, 16'h0004), 1, 0, 0, 0, 0, s);
    step(add_dep, 1, 0, 0, 0, 0, s);
    check("stall_seen", 64'(s), 64'd1);
    step(add_dep, 1, 0, 0, 0, 0, s);
    check("stall_one_cycle", 64'(s), 64'd0);

    // Load-use with flush in the same cycle: bubble, no stall.
    step(mk(8, 2, 0, 0, 16'h0008), 1, 0, 0, 0, 0, s);
    step(add_dep, 1, 1, 0, 0, 0, s);
    check("flush_beats_stall", 64'(s), 64'd0);

    // Write to r0 is discarded.
    step(mk(0, 0, 0, 0, 0), 0, 0, 1, 3'd0, 32'hFFFF_FFFF, s);
    step(mk(1, 5, 0, 0, 0), 1, 0, 0, 0, 0, s);

    // Same-cycle write and read of r4.
    step(mk(0, 0, 0, 0, 0), 0, 0, 1, 3'd4, 32'h1234_5678, s);
    step(mk(1, 6, 4, 4, 0), 1, 0, 1, 3'd4, 32'hA5A5_A5A5, s);
    step(mk(1, 6, 4, 0, 0), 1, 0, 0, 0, 0, s);

    // SW with negative immediate, then reset mid-stream.
    step(mk(9, 1, 3, 4, 16'h8000), 1, 0, 0, 0, 0, s);
    @(negedge clk);
    in_valid = 0;
    check("sw_present", 64'({WMemEn, isMemInst, WRegEn_out}), 64'b110);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    @(negedge clk);
    rst = 1'b0;

    // Reset during a stall: the held instruction is accepted afterwards.
    step(mk(0, 0, 0, 0, 0), 0, 0, 1, 3'd2, 32'h0000_0077, s);
    step(mk(8, 2, 0, 0, 16'h0010), 1, 0, 0, 0, 0, s);
    @(negedge clk);
    inst = add_dep; in_valid = 1;
    #1;
    check("stall_before_reset", 64'(stall_out), 64'd1);
    rst = 1'b1;
    #1;
    check("stall_cleared_by_reset", 64'(stall_out), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(add_dep, 1, 0, 0, 0, 0, s);
    check("accept_after_reset", 64'(s), 64'd0);

    // Randomized stream; fetch holds the instruction while stalled.
    cur = $urandom;
    for (int n = 0; n < 400; n++) begin
      logic v, f, we;
      v  = ($urandom_range(0, 9) < 8);
      f  = ($urandom_range(0, 9) == 0);
      we = $urandom_range(0, 1);
      step(cur, v, f, we, RA'($urandom), $urandom, s);
      if (!(s && v)) begin
        cur = $urandom;
        if ($urandom_range(0, 2) == 0) cur[31:28] = 4'd8;
      end
    end

    @(negedge clk);
    in_valid = 0; flush = 0; WRegEn_in = 0;
    @(posedge clk);
    #2;
    check("queue_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
